multicore_rr: RTL

Parametrised core-farm controller for N rede_float cores. It releases the per-core resets in a staggered sequence with a programmable spacing, and captures each core's tagged result into a one-entry holding slot. It merges the slots onto a single valid/ready output stream through a fair round-robin arbiter, and flags overflow per core. Cores are instantiated beside it in the multicore top level; this block holds all the sequential control that the top level previously did inline.

---
 rtl/multicore_pkg.sv | 46 ++++
 rtl/multicore_slot.sv | 61 ++++++
 rtl/multicore_rr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore farm controller and sibling arbiters.
package multicore_pkg;

  localparam int OUT_W_DEF = 28;
  localparam int TAG_W_DEF = 4;
  localparam int RR_MAX    = 64;

  typedef enum logic {SEQ_RELEASE = 1'b0, SEQ_DONE = 1'b1} seq_state_e;

  // Holding-slot layout at the default core widths.
  typedef struct packed {
    logic                        full;
    logic [TAG_W_DEF-1:0]        tag;
    logic signed [OUT_W_DEF-1:0] data;
  } slot_t;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic rr_pick_t rr_first(input logic [RR_MAX-1:0] req,
                                        input logic [5:0]        ptr,
                                        input logic [6:0]        n);
    rr_pick_t   pick;
    logic [6:0] j;
    pick = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      j = {1'b0, ptr} + 7'(k);
      if (j >= n) begin
        j = j - n;
      end else begin
        j = j;
      end
      if ((7'(k) < n) && !pick.found && req[j[5:0]]) begin
        pick.found = 1'b1;
        pick.idx   = j[5:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multicore_slot.sv
// One-entry holding slot for a single core result, with sticky overflow flag.
module multicore_slot
  import multicore_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restart,
  input  logic                    i_in_rst,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic signed [OUT_W-1:0] i_data,
  input  logic                    i_drain,
  output logic                    o_full,
  output logic [TAG_W-1:0]        o_tag,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_ovf
);

  logic                    r_full;
  logic [TAG_W-1:0]        r_tag;
  logic signed [OUT_W-1:0] r_data;
  logic                    r_ovf;
  logic                    w_valid;

  assign w_valid = !i_in_rst && (i_tag != '0);

  // A result arriving while the slot drains replaces the outgoing entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_tag  <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else if (restart) begin
      r_full <= 1'b0;
      r_tag  <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else if (w_valid) begin
      if (!r_full || i_drain) begin
        r_full <= 1'b1;
        r_tag  <= i_tag;
        r_data <= i_data;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (i_drain) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  assign o_full = r_full;
  assign o_tag  = r_tag;
  assign o_data = r_data;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/multicore_rr.sv
// Core-farm controller: staggered core reset release, per-core result capture,
// and round-robin merge of the captured results onto one valid/ready stream.
module multicore_rr
  import multicore_pkg::*;
#(
  parameter int N_CORES = 31,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int STAGGER = 12,
  parameter int CNT_W   = 13,
  parameter int ID_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic                       seq_en,
  output logic [N_CORES-1:0]         core_rst,
  input  logic [N_CORES*OUT_W-1:0]   core_io_out,
  input  logic [N_CORES*TAG_W-1:0]   core_out_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [OUT_W-1:0]    m_data,
  output logic [TAG_W-1:0]           m_tag,
  output logic [ID_W-1:0]            m_core,
  output logic                       all_up,
  output logic [N_CORES-1:0]         ovf
);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STAGGER - 1);
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(N_CORES - 1);
  localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

  seq_state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [N_CORES-1:0]    r_core_rst, w_core_rst_nxt;
  logic                  r_all_up, w_all_up_nxt;

  logic                    r_m_valid;
  logic signed [OUT_W-1:0] r_m_data;
  logic [TAG_W-1:0]        r_m_tag;
  logic [ID_W-1:0]         r_m_core;
  logic [ID_W-1:0]         r_ptr;

  logic [N_CORES-1:0]      w_full;
  logic [N_CORES-1:0]      w_drain;
  logic [TAG_W-1:0]        w_slot_tag  [N_CORES];
  logic signed [OUT_W-1:0] w_slot_data [N_CORES];
  logic [RR_MAX-1:0]       w_req;
  rr_pick_t                w_pick;
  logic [ID_W-1:0]         w_grant;
  logic                    w_load;
  logic                    w_fire;
  logic [TAG_W-1:0]        w_sel_tag;
  logic signed [OUT_W-1:0] w_sel_data;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SEQ_RELEASE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_core_rst <= '1;
      r_all_up   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_all_up   <= w_all_up_nxt;
    end
  end

  // Sequencer next state: release core idx when cnt is 0, step idx every STAGGER cycles.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_core_rst_nxt = r_core_rst;
    w_all_up_nxt   = r_all_up;
    if (restart) begin
      w_state_nxt    = SEQ_RELEASE;
      w_idx_nxt      = '0;
      w_cnt_nxt      = '0;
      w_core_rst_nxt = '1;
      w_all_up_nxt   = 1'b0;
    end else begin
      case (r_state)
        SEQ_RELEASE: begin
          if (seq_en) begin
            if (r_cnt == '0) begin
              w_core_rst_nxt = r_core_rst & ~(ONE_HOT0 << r_idx);
            end else begin
              w_core_rst_nxt = r_core_rst;
            end
            if (r_cnt == CNT_LAST) begin
              w_cnt_nxt = '0;
              if (r_idx == ID_LAST) begin
                w_state_nxt  = SEQ_DONE;
                w_all_up_nxt = 1'b1;
              end else begin
                w_idx_nxt = r_idx + ID_W'(1);
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        SEQ_DONE: begin
          w_all_up_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = SEQ_RELEASE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_slot
    multicore_slot #(
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart),
      .i_in_rst (r_core_rst[g]),
      .i_tag    (core_out_en[g*TAG_W +: TAG_W]),
      .i_data   (core_io_out[g*OUT_W +: OUT_W]),
      .i_drain  (w_drain[g]),
      .o_full   (w_full[g]),
      .o_tag    (w_slot_tag[g]),
      .o_data   (w_slot_data[g]),
      .o_ovf    (ovf[g])
    );
  end

  // Zero-extend the full flags to the shared arbiter width.
  always_comb begin
    w_req              = '0;
    w_req[N_CORES-1:0] = w_full;
  end

  assign w_pick  = rr_first(w_req, 6'(r_ptr), 7'(N_CORES));
  assign w_grant = w_pick.idx[ID_W-1:0];
  assign w_load  = !r_m_valid || m_ready;
  assign w_fire  = w_load && w_pick.found;

  // Drain strobe and data mux for the granted slot.
  always_comb begin
    w_drain    = '0;
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_drain[i] = w_fire;
        w_sel_tag  = w_slot_tag[i];
        w_sel_data = w_slot_data[i];
      end else begin
        w_drain[i] = 1'b0;
      end
    end
  end

  // Output register; contents only change when the downstream can take them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_tag   <= '0;
      r_m_core  <= '0;
      r_ptr     <= '0;
    end else if (restart) begin
      r_m_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_pick.found) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_sel_data;
        r_m_tag   <= w_sel_tag;
        r_m_core  <= w_grant;
        r_ptr     <= (w_grant == ID_LAST) ? '0 : w_grant + ID_W'(1);
      end else begin
        r_m_valid <= 1'b0;
      end
    end else begin
      r_m_valid <= r_m_valid;
    end
  end

  assign core_rst = r_core_rst;
  assign all_up   = r_all_up;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_tag    = r_m_tag;
  assign m_core   = r_m_core;

endmodule
